// File: rtl/reg_file_pkg.sv
// Shared opcodes and controller state encoding for the command-driven register file.
package reg_file_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_MOVE  = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWAP2 = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/reg_file_array.sv
// Register storage: one synchronous write port, three combinational read ports.
module reg_file_array
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] peek_addr,
    output logic [DATA_W-1:0] rs_rdata,
    output logic [DATA_W-1:0] rd_rdata,
    output logic [DATA_W-1:0] peek_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage array with asynchronous clear of every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rs_rdata   = mem_q[rs_addr];
    assign rd_rdata   = mem_q[rd_addr];
    assign peek_rdata = mem_q[peek_addr];

endmodule

// File: rtl/reg_file_ctrl.sv
// Command controller for the register file: valid/ready intake, two-cycle swap,
// sequential bulk clear, registered result and an always-on peek port.
module reg_file_ctrl
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              clear_done,
    input  logic [ADDR_W-1:0] peek_addr,
    output logic [DATA_W-1:0] peek_data
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] swap_rd_q, swap_rd_d;
    logic [DATA_W-1:0] tmp_q, tmp_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              clear_done_q, clear_done_d;
    logic [DATA_W-1:0] peek_data_q;

    logic              accept_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rs_rdata_s, rd_rdata_s, peek_rdata_s;

    reg_file_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we        (we_s),
        .waddr     (waddr_s),
        .wdata     (wdata_s),
        .rs_addr   (rs),
        .rd_addr   (rd),
        .peek_addr (peek_addr),
        .rs_rdata  (rs_rdata_s),
        .rd_rdata  (rd_rdata_s),
        .peek_rdata(peek_rdata_s)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept_s  = cmd_valid & cmd_ready;

    // State, sequencing and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {ADDR_W{1'b0}};
            swap_rd_q    <= {ADDR_W{1'b0}};
            tmp_q        <= {DATA_W{1'b0}};
            data_out_q   <= {DATA_W{1'b0}};
            out_valid_q  <= 1'b0;
            clear_done_q <= 1'b0;
            peek_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            swap_rd_q    <= swap_rd_d;
            tmp_q        <= tmp_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            clear_done_q <= clear_done_d;
            peek_data_q  <= peek_rdata_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (op == OP_SWAP)) begin
                    state_d = ST_SWAP2;
                end else if (accept_s && (op == OP_CLEAR)) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWAP2: state_d = ST_IDLE;
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port control and result registers; the swap's first half frees rs early
    always_comb begin
        we_s         = 1'b0;
        waddr_s      = rd;
        wdata_s      = {DATA_W{1'b0}};
        cnt_d        = cnt_q;
        swap_rd_d    = swap_rd_q;
        tmp_d        = tmp_q;
        data_out_d   = data_out_q;
        out_valid_d  = 1'b0;
        clear_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_LOAD: begin
                            we_s        = 1'b1;
                            waddr_s     = rd;
                            wdata_s     = data_in;
                            data_out_d  = data_in;
                            out_valid_d = 1'b1;
                        end
                        OP_MOVE: begin
                            we_s        = 1'b1;
                            waddr_s     = rd;
                            wdata_s     = rs_rdata_s;
                            data_out_d  = rs_rdata_s;
                            out_valid_d = 1'b1;
                        end
                        OP_READ: begin
                            data_out_d  = rs_rdata_s;
                            out_valid_d = 1'b1;
                        end
                        OP_SWAP: begin
                            we_s      = 1'b1;
                            waddr_s   = rs;
                            wdata_s   = rd_rdata_s;
                            tmp_d     = rs_rdata_s;
                            swap_rd_d = rd;
                        end
                        OP_CLEAR: cnt_d = {ADDR_W{1'b0}};
                        default:  we_s  = 1'b0;
                    endcase
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_SWAP2: begin
                we_s        = 1'b1;
                waddr_s     = swap_rd_q;
                wdata_s     = tmp_q;
                data_out_d  = tmp_q;
                out_valid_d = 1'b1;
            end
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = cnt_q;
                wdata_s = {DATA_W{1'b0}};
                cnt_d   = cnt_q + ADDR_W'(1'b1);
                if (cnt_q == CNT_LAST) begin
                    clear_done_d = 1'b1;
                end else begin
                    clear_done_d = 1'b0;
                end
            end
            default: we_s = 1'b0;
        endcase
    end

    assign data_out   = data_out_q;
    assign out_valid  = out_valid_q;
    assign clear_done = clear_done_q;
    assign peek_data  = peek_data_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: directed scenarios plus random commands against an array model,
// with a second 32-bit/16-entry instance for the parameter sweep.
module tb_reg_file_ctrl;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_cmd_valid = 1'b0, a_cmd_ready, a_ov, a_busy, a_cd;
    logic [2:0]  a_op = 3'd0, a_rs = 3'd0, a_rd = 3'd0, a_peek = 3'd0;
    logic [15:0] a_din = 16'd0, a_dout, a_pd;

    logic        b_cmd_valid = 1'b0, b_cmd_ready, b_ov, b_busy, b_cd;
    logic [2:0]  b_op = 3'd0;
    logic [3:0]  b_rs = 4'd0, b_rd = 4'd0, b_peek = 4'd0;
    logic [31:0] b_din = 32'd0, b_dout, b_pd;

    logic [15:0] mem_a [8];
    logic [15:0] exp_a;

    reg_file_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .op(a_op), .rs(a_rs), .rd(a_rd), .data_in(a_din), .data_out(a_dout),
        .out_valid(a_ov), .busy(a_busy), .clear_done(a_cd),
        .peek_addr(a_peek), .peek_data(a_pd)
    );

    reg_file_ctrl #(.DATA_W(32), .ADDR_W(4)) dut32 (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .op(b_op), .rs(b_rs), .rd(b_rd), .data_in(b_din), .data_out(b_dout),
        .out_valid(b_ov), .busy(b_busy), .clear_done(b_cd),
        .peek_addr(b_peek), .peek_data(b_pd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_a_ov", 32'(a_ov), 32'd0);
        chk("rst_a_cd", 32'(a_cd), 32'd0);
        chk("rst_a_dout", 32'(a_dout), 32'd0);
        chk("rst_a_peek", 32'(a_pd), 32'd0);
        chk("rst_a_ready", 32'(a_cmd_ready), 32'd1);
        chk("rst_b_ready", 32'(b_cmd_ready), 32'd1);
        chk("rst_b_dout", b_dout, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[i] = 16'd0;
        exp_a = 16'd0;
    endtask

    task automatic checkall_a();
        for (int i = 0; i < 8; i++) begin
            a_peek = 3'(i);
            step();
            chk("peek_all", 32'(a_pd), 32'(mem_a[i]));
        end
    endtask

    // Issue one command to the 16-bit instance and check it against the array model.
    task automatic issue_a(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rd,
                           input logic [15:0] din);
        logic [15:0] pk, va, vb;
        logic [2:0]  pa;
        int n;
        chk("ready_before", 32'(a_cmd_ready), 32'd1);
        pa = 3'($urandom_range(0, 7));
        a_peek = pa;
        pk = mem_a[pa];
        a_cmd_valid = 1'b1; a_op = op; a_rs = rs; a_rd = rd; a_din = din;
        step();
        a_cmd_valid = 1'b0;
        chk("peek_lag", 32'(a_pd), 32'(pk));
        case (op)
            OP_LOAD: begin
                chk("load_ov", 32'(a_ov), 32'd1);
                chk("load_dout", 32'(a_dout), 32'(din));
                mem_a[rd] = din; exp_a = din;
            end
            OP_MOVE: begin
                chk("move_ov", 32'(a_ov), 32'd1);
                chk("move_dout", 32'(a_dout), 32'(mem_a[rs]));
                exp_a = mem_a[rs]; mem_a[rd] = mem_a[rs];
            end
            OP_READ: begin
                chk("read_ov", 32'(a_ov), 32'd1);
                chk("read_dout", 32'(a_dout), 32'(mem_a[rs]));
                exp_a = mem_a[rs];
            end
            OP_SWAP: begin
                va = mem_a[rs]; vb = mem_a[rd];
                chk("swap_busy", 32'(a_cmd_ready), 32'd0);
                chk("swap_ov0", 32'(a_ov), 32'd0);
                step();
                chk("swap_ov", 32'(a_ov), 32'd1);
                chk("swap_dout", 32'(a_dout), 32'(va));
                chk("swap_ready", 32'(a_cmd_ready), 32'd1);
                mem_a[rs] = vb; mem_a[rd] = va; exp_a = va;
            end
            OP_CLEAR: begin
                chk("clr_busy", 32'(a_busy), 32'd1);
                a_cmd_valid = 1'b1; a_op = OP_READ; a_rs = rs;
                n = 0;
                while (a_busy && n < 40) begin
                    chk("clr_no_ov", 32'(a_ov), 32'd0);
                    step();
                    n++;
                end
                chk("clr_cycles", 32'(n), 32'd8);
                chk("clr_done", 32'(a_cd), 32'd1);
                step();
                a_cmd_valid = 1'b0;
                chk("held_read_ov", 32'(a_ov), 32'd1);
                chk("held_read_dout", 32'(a_dout), 32'd0);
                chk("clr_done_pulse", 32'(a_cd), 32'd0);
                for (int i = 0; i < 8; i++) mem_a[i] = 16'd0;
                exp_a = 16'd0;
            end
            default: begin
                chk("nop_ov", 32'(a_ov), 32'd0);
                chk("nop_dout", 32'(a_dout), 32'(exp_a));
                chk("nop_ready", 32'(a_cmd_ready), 32'd1);
            end
        endcase
    endtask

    initial begin
        int n;
        step();
        do_reset();

        issue_a(OP_LOAD, 3'd0, 3'd2, 16'h1234);
        issue_a(OP_READ, 3'd2, 3'd0, 16'h0000);
        a_peek = 3'd2;
        step();
        chk("peek_r2", 32'(a_pd), 32'h1234);

        issue_a(OP_LOAD, 3'd0, 3'd1, 16'h5678);
        issue_a(OP_MOVE, 3'd1, 3'd3, 16'h0000);
        issue_a(OP_MOVE, 3'd3, 3'd3, 16'h0000);
        issue_a(OP_LOAD, 3'd0, 3'd4, 16'h0303);
        issue_a(OP_LOAD, 3'd0, 3'd5, 16'hABCD);
        issue_a(OP_SWAP, 3'd4, 3'd5, 16'h0000);
        issue_a(OP_SWAP, 3'd5, 3'd5, 16'h0000);
        checkall_a();

        for (int i = 0; i < 8; i++) issue_a(OP_LOAD, 3'd0, 3'(i), 16'(i * 16'h1111 + 16'h0001));
        issue_a(OP_CLEAR, 3'd6, 3'd0, 16'h0000);
        checkall_a();

        // Reset while the swap is half done
        issue_a(OP_LOAD, 3'd0, 3'd6, 16'h00F0);
        issue_a(OP_LOAD, 3'd0, 3'd7, 16'h0F00);
        a_cmd_valid = 1'b1; a_op = OP_SWAP; a_rs = 3'd6; a_rd = 3'd7;
        step();
        a_cmd_valid = 1'b0;
        chk("mid_swap_busy", 32'(a_busy), 32'd1);
        do_reset();
        checkall_a();

        // Reset with the clear counter at 3
        for (int i = 0; i < 8; i++) issue_a(OP_LOAD, 3'd0, 3'(i), 16'hA5A5);
        a_cmd_valid = 1'b1; a_op = OP_CLEAR;
        step();
        a_cmd_valid = 1'b0;
        step(); step(); step();
        chk("mid_clr_busy", 32'(a_busy), 32'd1);
        do_reset();
        checkall_a();

        for (int k = 0; k < 80; k++) begin
            issue_a(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 16'($urandom()));
        end
        checkall_a();

        // Wider, deeper instance
        b_peek = 4'd15;
        b_cmd_valid = 1'b1; b_op = OP_LOAD; b_rd = 4'd15; b_din = 32'hDEADBEEF;
        step();
        chk("b_load_ov", 32'(b_ov), 32'd1);
        chk("b_load_dout", b_dout, 32'hDEADBEEF);
        b_op = OP_READ; b_rs = 4'd15;
        step();
        chk("b_read_ov", 32'(b_ov), 32'd1);
        chk("b_read_dout", b_dout, 32'hDEADBEEF);
        chk("b_peek15", b_pd, 32'hDEADBEEF);
        b_op = 3'd7; b_rd = 4'd15; b_din = 32'h0;
        step();
        chk("b_op7_ov", 32'(b_ov), 32'd0);
        chk("b_op7_dout", b_dout, 32'hDEADBEEF);
        chk("b_op7_busy", 32'(b_busy), 32'd0);
        b_op = OP_CLEAR;
        step();
        b_cmd_valid = 1'b0;
        step();
        chk("b_op7_peek", b_pd, 32'hDEADBEEF);
        n = 1;
        while (b_busy && n < 60) begin
            step();
            n++;
        end
        chk("b_clr_cycles", 32'(n), 32'd16);
        chk("b_clr_done", 32'(b_cd), 32'd1);
        step();
        chk("b_peek_clr", b_pd, 32'd0);
        chk("b_clr_done_pulse", 32'(b_cd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Parametrised register file with command-driven transfers: load, move, read, swap and bulk clear.
- Successor to the fixed 8x16 move/in register store: generalised width/depth, adds valid/ready command handshake, multi-cycle ops, registered result with valid flag, and an independent peek read port.
- Sits between a sequencer/datapath controller and the datapath registers.
- No tri-state outputs; all outputs are driven at all times.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- op  in  3  opcode (see package).
- rs  in  ADDR_W  source register index.
- rd  in  ADDR_W  destination register index.
- data_in  in  DATA_W  load data.
- data_out  out  DATA_W  registered result.
- out_valid  out  1  one-cycle pulse; data_out is valid.
- busy  out  1  multi-cycle op in progress (equals ~cmd_ready).
- clear_done  out  1  one-cycle pulse when CLEAR completes.
- peek_addr  in  ADDR_W  debug read index.
- peek_data  out  DATA_W  reg[peek_addr] registered, 1-cycle latency, always active.

Behaviour:
- Reset (asynchronous, any state):
  - All DEPTH registers = 0; data_out = 0; out_valid = 0; clear_done = 0; peek_data = 0.
  - State = IDLE; clear counter = 0; swap temp = 0.
  - Reset mid-SWAP or mid-CLEAR aborts the op; all registers are zero afterwards.
- Handshake:
  - A command is accepted at a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = 1 only in IDLE.
  - cmd_valid while not ready is ignored; the sender must hold the command.
- FSM states: IDLE, SWAP2, CLEAR.
- Ops accepted in IDLE; "edge" is the accept edge:
  - NOP (0): no effect.
  - LOAD (1): reg[rd] <= data_in. At the same edge, data_out <= data_in and out_valid = 1 for the next cycle.
  - MOVE (2): reg[rd] <= reg[rs], using the pre-edge value. data_out <= reg[rs]; out_valid pulses. rs==rd leaves the register unchanged.
  - READ (3): data_out <= reg[rs]; out_valid pulses; no write.
  - SWAP (4):
    - Accept edge: tmp <= reg[rs]; reg[rs] <= reg[rd]; go to SWAP2.
    - Next edge: reg[rd] <= tmp; data_out <= tmp; out_valid pulses; go to IDLE.
    - Total of 2 cycles with cmd_ready low for 1 cycle. rs==rd leaves contents unchanged.
  - CLEAR (5):
    - Go to CLEAR with counter = 0.
    - Each cycle: reg[counter] <= 0; counter increments.
    - At counter = DEPTH-1: write 0, clear_done pulses on the following cycle, return to IDLE.
    - Exactly DEPTH cycles busy; the counter wraps to 0.
  - Opcodes 6 and 7: treated as NOP and accepted.
- out_valid and clear_done are 0 in every cycle not stated above.
- data_out holds its last value when out_valid = 0.
- One write per cycle maximum; single write port.
- peek_data <= reg[peek_addr] every edge. It reflects the pre-edge contents, so it lags a write by one cycle, and it operates in all states.

Decomposition:
- Package reg_file_pkg:
  - Opcode constants: OP_NOP=0, OP_LOAD=1, OP_MOVE=2, OP_READ=3, OP_SWAP=4, OP_CLEAR=5.
  - FSM state encoding: IDLE, SWAP2, CLEAR.
- Sub-module reg_file_array (parametrised DATA_W/ADDR_W):
  - Storage with async reset.
  - One write port (we, waddr, wdata).
  - Three combinational read ports: rs, rd, peek.
- reg_file_ctrl holds the FSM, counter, temp and output registers.

Test Plan:
- Reset then LOAD rd=2 with 16'h1234, then READ rs=2 -> out_valid pulses twice, data_out = 1234 both times; peek_addr=2 gives peek_data = 1234.
- LOAD r1=16'h5678, then MOVE rs=1 rd=3 -> reg3 = 5678, data_out = 5678, reg1 unchanged; MOVE rs=rd=3 -> reg3 still 5678.
- LOAD r4=16'h0303, r5=16'hABCD, then SWAP rs=4 rd=5 -> cmd_ready low 1 cycle, r4=ABCD, r5=0303, data_out = 0303 on the completion cycle; SWAP rs=rd=5 -> r5 = 0303.
- Fill all 8 registers nonzero, then CLEAR -> busy for 8 cycles, a READ held with cmd_valid is accepted only after clear_done, and all peeks return 0.
- Assert rst during SWAP2 and again at CLEAR counter=3 -> all registers 0, out_valid 0, state IDLE, cmd_ready = 1 immediately after release.
- Parameter sweep DATA_W=32, ADDR_W=4: LOAD r15=32'hDEADBEEF, READ -> DEADBEEF; CLEAR takes 16 cycles; op=7 -> no state change.
